// File: rtl/keypad_pkg.sv
//------------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 keypad scan controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    HOLD     = 2'd3
  } state_t;

  // Index of the lowest set bit; scanning from the top down lets the
  // lowest column overwrite any higher hit.
  function automatic logic [1:0] lowest_set(input logic [NUM_COLS-1:0] bits);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (bits[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan_ctrl_if.sv
//------------------------------------------------------------------------------
// keypad_scan_ctrl_if
// Keypad pin and code-handshake bundle. The master side is the scan
// controller (drives rows and the code/valid pair); the slave side is the
// keypad plus downstream consumer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface keypad_scan_ctrl_if;
  import keypad_pkg::*;

  logic [NUM_COLS-1:0] col;
  logic                ready;
  logic [NUM_ROWS-1:0] row;
  logic [CODE_W-1:0]   code;
  logic                valid;

  modport master (input col, input ready, output row, output code, output valid);
  modport slave  (output col, output ready, input row, input code, input valid);

endinterface

`default_nettype wire

// File: rtl/keypad_dwell_timer.sv
//------------------------------------------------------------------------------
// keypad_dwell_timer
// Free-running 0..SCAN_DIV-1 counter; 'sample' marks the last cycle of
// each row dwell, when the column lines have had time to settle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module keypad_dwell_timer #(
  parameter int SCAN_DIV = 7
) (
  input  logic Clk,
  input  logic Reset,
  output logic sample
);

  localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  // Dwell counter wraps at the sample point and never stalls.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign sample = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
//------------------------------------------------------------------------------
// keypad_scan_ctrl
// 4x4 matrix keypad scanner: one-hot row drive, dwell-end column sampling,
// press/release debounce, and valid/ready hand-off of the 4-bit key code.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of a held key every
// REPEAT_DLY held samples).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 7,
  parameter int DEB_CNT    = 3,
  parameter int REPEAT_DLY = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  keypad_scan_ctrl_if.master bus
);

  // Stable counter doubles as the release counter while in HOLD.
  localparam int            SW      = $clog2(DEB_CNT + 1);
  localparam logic [SW-1:0] DEB_TGT = SW'(DEB_CNT);

  state_t          state, state_nx;
  logic [1:0]      row_idx, row_idx_nx;
  logic [1:0]      col_idx, col_idx_nx;
  logic [CODE_W-1:0] code_r, code_nx;
  logic [SW-1:0]   stable, stable_nx, stable_inc;
  logic            sample;
  logic            hit;

`ifdef KEYPAD_REPEAT_EN
  localparam int            RW      = $clog2(REPEAT_DLY + 1);
  localparam logic [RW-1:0] REP_TGT = RW'(REPEAT_DLY);
  logic [RW-1:0]   held, held_nx, held_inc;
  assign held_inc = held + RW'(1);
`endif

  keypad_dwell_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_dwell (
    .Clk    (Clk),
    .Reset  (Reset),
    .sample (sample)
  );

  assign hit        = bus.col[col_idx];
  assign stable_inc = stable + SW'(1);

  // Next-state logic: sample-point decisions for scan, debounce and hold.
  always_comb begin
    state_nx   = state;
    row_idx_nx = row_idx;
    col_idx_nx = col_idx;
    code_nx    = code_r;
    stable_nx  = stable;
`ifdef KEYPAD_REPEAT_EN
    held_nx    = held;
`endif
    case (state)
      SCAN: begin
        if (sample) begin
          if (bus.col == '0) begin
            row_idx_nx = row_idx + 2'd1;
          end else begin
            // First hit in scan order wins; the code is {row, col}.
            col_idx_nx = lowest_set(bus.col);
            code_nx    = {row_idx, lowest_set(bus.col)};
            stable_nx  = SW'(1);
            state_nx   = (DEB_CNT == 1) ? EMIT : DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (hit) begin
            stable_nx = stable_inc;
            if (stable_inc == DEB_TGT) state_nx = EMIT;
          end else begin
            // Bounce or glitch: drop the candidate and move on.
            stable_nx  = '0;
            row_idx_nx = row_idx + 2'd1;
            state_nx   = SCAN;
          end
        end
      end
      EMIT: begin
        // Release is deliberately ignored until the consumer takes the code.
        if (bus.ready) begin
          state_nx  = HOLD;
          stable_nx = '0;
`ifdef KEYPAD_REPEAT_EN
          held_nx   = '0;
`endif
        end
      end
      HOLD: begin
        if (sample) begin
          if (!hit) begin
            stable_nx = stable_inc;
`ifdef KEYPAD_REPEAT_EN
            held_nx   = '0;
`endif
            if (stable_inc == DEB_TGT) begin
              stable_nx  = '0;
              row_idx_nx = row_idx + 2'd1;
              state_nx   = SCAN;
            end
          end else begin
            stable_nx = '0;
`ifdef KEYPAD_REPEAT_EN
            held_nx   = held_inc;
            if (held_inc == REP_TGT) begin
              held_nx  = '0;
              state_nx = EMIT;
            end
`endif
          end
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  // State and datapath registers; reset clears any press in progress.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= SCAN;
      row_idx <= 2'd0;
      col_idx <= 2'd0;
      code_r  <= '0;
      stable  <= '0;
`ifdef KEYPAD_REPEAT_EN
      held    <= '0;
`endif
    end else begin
      state   <= state_nx;
      row_idx <= row_idx_nx;
      col_idx <= col_idx_nx;
      code_r  <= code_nx;
      stable  <= stable_nx;
`ifdef KEYPAD_REPEAT_EN
      held    <= held_nx;
`endif
    end
  end

  assign bus.row   = 4'b0001 << row_idx;
  assign bus.code  = code_r;
  assign bus.valid = (state == EMIT);

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
//------------------------------------------------------------------------------
// tb_keypad_scan_ctrl
// Self-checking bench: keypad pin model, cycle-level behavioural reference,
// per-cycle compare, and directed scenarios with literal expectations.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV   = 2;
  localparam int DEB_CNT    = 2;
  localparam int REPEAT_DLY = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] key = 16'h0;

  int checks = 0;
  int failures = 0;

  keypad_scan_ctrl_if bus();

  keypad_scan_ctrl #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_CNT    (DEB_CNT),
    .REPEAT_DLY (REPEAT_DLY)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Keypad matrix: a pressed key shorts its row to its column.
  always_comb begin
    bus.col = 4'b0000;
    for (int r = 0; r < 4; r++)
      if (bus.row[r]) bus.col = bus.col | key[4*r +: 4];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: integer bookkeeping of scan position and key phase.
  localparam int M_SCAN = 0, M_DEB = 1, M_EMIT = 2, M_HOLD = 3;
  int m_cnt = 0, m_ridx = 0, m_mode = M_SCAN, m_cidx = 0, m_code = 0;
  int m_stab = 0, m_rel = 0, m_held = 0, m_edges = 0, m_hit_cyc = -1;

  always @(posedge Clk or posedge Reset) begin : model
    bit         smp;
    bit         on;
    logic [3:0] c;
    int         old_mode;
    if (Reset) begin
      m_cnt = 0; m_ridx = 0; m_mode = M_SCAN; m_cidx = 0; m_code = 0;
      m_stab = 0; m_rel = 0; m_held = 0; m_hit_cyc = -1;
    end else begin
      smp      = (m_cnt == SCAN_DIV - 1);
      c        = key[4*m_ridx +: 4];
      on       = c[m_cidx];
      old_mode = m_mode;
      m_cnt    = (m_cnt + 1) % SCAN_DIV;
      if (old_mode == M_EMIT) begin
        if (bus.ready) begin m_mode = M_HOLD; m_rel = 0; m_held = 0; end
      end else if (smp) begin
        case (old_mode)
          M_SCAN: begin
            if (c == 0) m_ridx = (m_ridx + 1) % 4;
            else begin
              for (int i = 3; i >= 0; i--) if (c[i]) m_cidx = i;
              m_code    = 4 * m_ridx + m_cidx;
              m_stab    = 1;
              m_hit_cyc = m_edges;
              m_mode    = (DEB_CNT == 1) ? M_EMIT : M_DEB;
            end
          end
          M_DEB: begin
            if (on) begin
              m_stab++;
              if (m_stab == DEB_CNT) m_mode = M_EMIT;
            end else begin
              m_mode = M_SCAN; m_ridx = (m_ridx + 1) % 4;
            end
          end
          default: begin
            if (!on) begin
              m_rel++; m_held = 0;
              if (m_rel == DEB_CNT) begin m_mode = M_SCAN; m_ridx = (m_ridx + 1) % 4; end
            end else begin
              m_rel = 0;
`ifdef KEYPAD_REPEAT_EN
              m_held++;
              if (m_held == REPEAT_DLY) begin m_mode = M_EMIT; m_held = 0; end
`endif
            end
          end
        endcase
      end
      m_edges++;
    end
  end

  // Per-cycle compare plus acceptance and latency bookkeeping.
  int   acc_cnt = 0;
  logic [3:0] acc_code = 4'h0;
  logic [3:0] acc_row  = 4'h0;
  logic prev_valid = 1'b0;
  int   lat_seen = -1;

  always @(negedge Clk) begin
    check("row", {28'h0, bus.row}, 32'(4'b0001 << m_ridx));
    check("valid", {31'h0, bus.valid}, 32'(m_mode == M_EMIT));
    check("code", {28'h0, bus.code}, 32'(m_code));
    if (bus.valid && !prev_valid && m_hit_cyc >= 0 && m_hit_cyc != lat_seen) begin
      check("latency", 32'(m_edges - m_hit_cyc), 32'd3);
      lat_seen = m_hit_cyc;
    end
    if (bus.valid && bus.ready) begin
      acc_cnt++;
      acc_code = bus.code;
      acc_row  = bus.row;
    end
    prev_valid = bus.valid;
  end

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge Clk);
      seen = bus.valid;
    end
    check("valid_timeout", {31'h0, seen}, 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  logic [3:0]  seq [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                          4'b0100, 4'b1000, 4'b1000, 4'b0001};
  logic [15:0] pkeys [2] = '{16'd32, 16'd1024};
  logic [3:0]  pcodes[2] = '{4'd5, 4'd10};

  initial begin : stim
    int  a0;
    logic [3:0] prev_row;
    bit  found;
    bus.ready = 1'b1;
    #1 Reset = 1'b1;
    tick(3);
    check("rst_row", {28'h0, bus.row}, 32'h1);
    check("rst_valid", {31'h0, bus.valid}, 32'h0);
    check("rst_code", {28'h0, bus.code}, 32'h0);
    Reset = 1'b0;
    // Idle scan walks the rows, two cycles each.
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      check("row_seq", {28'h0, bus.row}, {28'h0, seq[i]});
    end

    // Key 0 pressed for 80 ns: one emit, row held until release debounced.
    tick(1);
    a0 = acc_cnt;
    key = 16'h0001;
    #80 key = 16'h0;
    tick(20);
    check("k0_count", 32'(acc_cnt - a0), 32'd1);
    check("k0_code", {28'h0, acc_code}, 32'h0);
    check("k0_row", {28'h0, acc_row}, 32'h1);

    // Two more keys in different rows and columns.
    for (int k = 0; k < 2; k++) begin
      a0 = acc_cnt;
      key = pkeys[k];
      wait_valid(40);
      tick(1);
      key = 16'h0;
      tick(20);
      check("press_count", 32'(acc_cnt - a0), 32'd1);
      check("press_code", {28'h0, acc_code}, {28'h0, pcodes[k]});
    end

    // Back-pressure: code held through release, then a single acceptance.
    bus.ready = 1'b0;
    a0 = acc_cnt;
    key = 16'd32;
    wait_valid(40);
    tick(3);
    key = 16'h0;
    tick(10);
    check("bp_valid", {31'h0, bus.valid}, 32'h1);
    check("bp_code", {28'h0, bus.code}, 32'h5);
    bus.ready = 1'b1;
    tick(20);
    check("bp_count", 32'(acc_cnt - a0), 32'd1);
    check("bp_acode", {28'h0, acc_code}, 32'h5);

    // One-sample glitch on key 0: no emit, scan resumes at row 1.
    found = 1'b0;
    prev_row = bus.row;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      found = (bus.row == 4'b0001) && (prev_row == 4'b1000);
      prev_row = bus.row;
    end
    check("glitch_sync", {31'h0, found}, 32'd1);
    a0 = acc_cnt;
    key = 16'h0001;
    tick(2);
    key = 16'h0;
    tick(2);
    check("glitch_row", {28'h0, bus.row}, 32'h2);
    check("glitch_valid", {31'h0, bus.valid}, 32'h0);
    check("glitch_count", 32'(acc_cnt - a0), 32'd0);

    // Reset while valid is up clears outputs without a clock edge.
    bus.ready = 1'b0;
    key = 16'h0001;
    wait_valid(40);
    tick(1);
    Reset = 1'b1;
    #1;
    check("arst_valid", {31'h0, bus.valid}, 32'h0);
    check("arst_row", {28'h0, bus.row}, 32'h1);
    check("arst_code", {28'h0, bus.code}, 32'h0);
    key = 16'h0;
    bus.ready = 1'b1;
    tick(2);

    // Held key 0 for 40 edges from reset release.
    Reset = 1'b0;
    key = 16'h0001;
    a0 = acc_cnt;
    tick(40);
    key = 16'h0;
    tick(20);
`ifdef KEYPAD_REPEAT_EN
    check("held_count", 32'(acc_cnt - a0), 32'd7);
`else
    check("held_count", 32'(acc_cnt - a0), 32'd1);
`endif
    check("held_code", {28'h0, acc_code}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule

`default_nettype wire

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. Drives one row at a time and samples the four column lines at the end of each row dwell. Debounces a single pressed key and hands its 4-bit code to the downstream consumer (display/encoder path) over a valid/ready handshake. Sits between the physical keypad pins and the code/seven-segment datapath, replacing free-running scan logic.

## Interface

Parameters:
- SCAN_DIV, 7: clock cycles each row is driven (dwell); minimum 2.
- DEB_CNT, 3: consecutive dwell-end samples needed to accept a press or a release; minimum 1.
- REPEAT_DLY, 8: held-key dwell samples between repeated emits (used only with KEYPAD_REPEAT_EN).

Ports:
- Clk  input  1  system clock; all state is updated on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- col  input  4  column sense; bit c high means the key at (driven row, c) is pressed.
- ready  input  1  consumer accepts code when valid && ready.
- row  output  4  one-hot row drive.
- code  output  4  key code = row_idx*4 + col_idx, matching key-bit index n → code n.
- valid  output  1  code is valid; held until accepted.

## Operation

- Reset values: row=4'b0001, row_idx=0, code=0, valid=0, state=SCAN, dwell/stable/repeat counters=0.
- A dwell counter counts 0..SCAN_DIV-1 continuously. The "sample point" is the cycle where the counter equals SCAN_DIV-1.
- SCAN: row=onehot(row_idx).
  - At sample point with col==0: row_idx advances, wrapping 3→0.
  - At sample point with col!=0: capture col_idx = lowest set bit, code=row_idx*4+col_idx, stable=1. If DEB_CNT==1 → EMIT, else → DEBOUNCE. Row does not advance.
- DEBOUNCE: row is held.
  - At a sample point where col[col_idx]==1: stable++. When stable reaches DEB_CNT → EMIT.
  - At a sample point where col[col_idx]==0: → SCAN, row_idx advances.
  - Other column bits are ignored.
- EMIT: valid=1 and code is stable. Key release is ignored while in EMIT. On valid&&ready → HOLD, valid=0 next cycle, stable=0.
- HOLD: row is held.
  - Each sample point with col[col_idx]==0 increments the release count; a sample with the bit high clears it.
  - When the release count reaches DEB_CNT → SCAN, row_idx advances.
- Multiple simultaneous keys: the first hit in scan order wins (row, then lowest column). Others are ignored until release.
- Reset mid-operation: valid drops immediately (async). Any press in progress is discarded.

## Timing

- Row changes only on the cycle after a sample point.
- Press latency: valid rises on the cycle after the sample point completing DEB_CNT consecutive hits. From the first hitting sample, that is (DEB_CNT-1)*SCAN_DIV+1 cycles.
- Handshake: valid and code are held constant while valid && !ready. Acceptance occurs on any cycle with valid && ready, including the first valid cycle.
- Minimum emit-to-next-press: DEB_CNT release samples plus a full rescan.

## Configuration

- KEYPAD_REPEAT_EN defined: HOLD also counts consecutive held samples (col[col_idx]==1). After REPEAT_DLY of them → EMIT with the same code; the held count resets.
- Undefined: exactly one emit per press; REPEAT_DLY is unused.

## Structure

- Shared package keypad_pkg: state enum (SCAN, DEBOUNCE, EMIT, HOLD), NUM_ROWS=4, NUM_COLS=4, CODE_W=4, and the lowest-set-bit encode function.
- One sub-module: keypad_dwell_timer (dwell counter producing the sample-point strobe, parameter SCAN_DIV).

## Test plan

Bench keypad model: col = key[4*row_idx +: 4] when row is driven. SCAN_DIV=2, DEB_CNT=2, ready=1 unless stated.
- Reset held, then released with key=0 → row cycles 0001→0010→0100→1000→0001, changing every 2 cycles; valid stays 0.
- key=16'h0001 for 80 ns → one valid pulse with code=0; row held at 0001 until release is debounced.
- key=32 → code=5; key=1024 → code=10. Each produces exactly one accepted valid, with latency 3 cycles from the first hitting sample.
- ready=0 with key=32 pressed then released → valid stays 1 and code=5 unchanged. Raising ready gives a single acceptance; no second emit.
- One-sample glitch (key=1 for exactly one sample point) → no valid; scan resumes at row 0010.
- Reset asserted while valid=1 → valid=0 and row=0001 asynchronously. With KEYPAD_REPEAT_EN, REPEAT_DLY=3 and key=1 held → code 0 re-emitted every 3 samples.
